// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, MSB-first bits out on x.
// Optional even-parity trailer bit per word when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic parity_q;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, next_state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic             load;
  logic             shift_en;
  logic             last_bit;

  assign last_bit = (bit_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (load) begin
        shreg   <= data_in;
        bit_cnt <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
        parity_q <= ^data_in;
`endif
      end else if (shift_en) begin
        shreg   <= {shreg[WIDTH-2:0], 1'b0};
        // Counter parks at zero once the word ends so it never wraps mid-word.
        bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
      end
    end
  end

  // Outputs decode only registered state; data_ready never looks at data_valid.
  always_comb begin
    next_state  = state;
    data_ready  = 1'b0;
    load        = 1'b0;
    shift_en    = 1'b0;
    x           = 1'b0;
    x_valid     = 1'b0;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        data_ready = 1'b1;
        if (data_valid) begin
          load       = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        x           = shreg[WIDTH-1];
        x_valid     = 1'b1;
        frame_start = (bit_cnt == '0);
        shift_en    = 1'b1;
        if (last_bit) begin
`ifdef BIT_SERIALIZER_PARITY_EN
          next_state = PARITY;
`else
          data_ready = 1'b1;
          if (data_valid) begin
            load       = 1'b1;
            next_state = SHIFT;
          end else begin
            next_state = IDLE;
          end
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        x          = parity_q;
        x_valid    = 1'b1;
        data_ready = 1'b1;
        if (data_valid) begin
          load       = 1'b1;
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer (WIDTH=8); frame length follows BIT_SERIALIZER_PARITY_EN.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       x;
  logic       x_valid;
  logic       frame_start;

  int checks;
  int errors;

  bit_serializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .x          (x),
    .x_valid    (x_valid),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Bit j of a frame: payload MSB-first, then even parity in slot 8.
  function automatic logic exp_bit(input logic [7:0] w, input int j);
    if (j < 8) return w[7-j];
    return ^w;
  endfunction

  // Observed vector is {x, x_valid, frame_start, data_ready}.
  task automatic test_reset;
    logic [3:0] obs, exp;
    reset = 1'b1; data_valid = 1'b0; data_in = '0;
    step();
    obs = {x, x_valid, frame_start, data_ready};
    checks++;
    if (obs !== 4'b0001) begin errors++; $display("FAIL reset_init got %b want 0001", obs); end
    reset = 1'b0; data_valid = 1'b1; data_in = 8'hAA;
    step();
    obs = {x, x_valid, frame_start, data_ready};
    checks++;
    if (obs !== 4'b1110) begin errors++; $display("FAIL reset_pre_word got %b want 1110", obs); end
    #3 reset = 1'b1;
    #1;
    obs = {x, x_valid, frame_start, data_ready};
    checks++;
    if (obs !== 4'b0001) begin errors++; $display("FAIL reset_async got %b want 0001", obs); end
    step();
    reset = 1'b0;
    obs = {x, x_valid, frame_start, data_ready};
    checks++;
    if (obs !== 4'b0001) begin errors++; $display("FAIL reset_release got %b want 0001", obs); end
    step();
    data_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      exp = {exp_bit(8'hAA, i), 1'b1, (i == 0), (i == FRAME-1)};
      obs = {x, x_valid, frame_start, data_ready};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_first_word[%0d] got %b want %b", i, obs, exp); end
      step();
    end
    obs = {x, x_valid, frame_start, data_ready};
    checks++;
    if (obs !== 4'b0001) begin errors++; $display("FAIL reset_drain got %b want 0001", obs); end
  endtask

  task automatic test_single_word;
    logic [3:0] obs, exp;
    logic [7:0] w;
    w = 8'hD0;
    data_in = w; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    data_in = 8'h00;
    for (int i = 0; i < FRAME; i++) begin
      exp = {exp_bit(w, i), 1'b1, (i == 0), (i == FRAME-1)};
      obs = {x, x_valid, frame_start, data_ready};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL single[%0d] got %b want %b", i, obs, exp); end
      step();
    end
    obs = {x, x_valid, frame_start, data_ready};
    checks++;
    if (obs !== 4'b0001) begin errors++; $display("FAIL single_idle got %b want 0001", obs); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] obs, exp;
    logic [7:0] w;
    int j;
    data_in = 8'h0D; data_valid = 1'b1;
    step();
    data_in = 8'hA5;
    for (int i = 0; i < 2*FRAME; i++) begin
      w = (i < FRAME) ? 8'h0D : 8'hA5;
      j = i % FRAME;
      exp = {exp_bit(w, j), 1'b1, (j == 0), (j == FRAME-1)};
      obs = {x, x_valid, frame_start, data_ready};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL b2b[%0d] got %b want %b", i, obs, exp); end
      if (i == 2*FRAME-1) data_valid = 1'b0;
      step();
    end
    obs = {x, x_valid, frame_start, data_ready};
    checks++;
    if (obs !== 4'b0001) begin errors++; $display("FAIL b2b_idle got %b want 0001", obs); end
  endtask

  task automatic test_stall;
    logic [3:0] obs, exp;
    data_in = 8'h3C; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      exp = {exp_bit(8'h3C, i), 1'b1, (i == 0), (i == FRAME-1)};
      obs = {x, x_valid, frame_start, data_ready};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL stall_w1[%0d] got %b want %b", i, obs, exp); end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      obs = {x, x_valid, frame_start, data_ready};
      checks++;
      if (obs !== 4'b0001) begin errors++; $display("FAIL stall_gap[%0d] got %b want 0001", i, obs); end
      if (i == 2) begin data_in = 8'hC3; data_valid = 1'b1; end
      step();
    end
    data_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      exp = {exp_bit(8'hC3, i), 1'b1, (i == 0), (i == FRAME-1)};
      obs = {x, x_valid, frame_start, data_ready};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL stall_w2[%0d] got %b want %b", i, obs, exp); end
      step();
    end
  endtask

  task automatic test_reset_mid_word;
    logic [3:0] obs, exp;
    data_in = 8'hFF; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = {1'b1, 1'b1, (i == 0), 1'b0};
      obs = {x, x_valid, frame_start, data_ready};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL midrst_bits[%0d] got %b want %b", i, obs, exp); end
      if (i < 2) step();
    end
    #4 reset = 1'b1;
    #1;
    obs = {x, x_valid, frame_start, data_ready};
    checks++;
    if (obs !== 4'b0001) begin errors++; $display("FAIL midrst_async got %b want 0001", obs); end
    step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      obs = {x, x_valid, frame_start, data_ready};
      checks++;
      if (obs !== 4'b0001) begin errors++; $display("FAIL midrst_discard[%0d] got %b want 0001", i, obs); end
      step();
    end
    data_in = 8'h81; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      exp = {exp_bit(8'h81, i), 1'b1, (i == 0), (i == FRAME-1)};
      obs = {x, x_valid, frame_start, data_ready};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL midrst_81[%0d] got %b want %b", i, obs, exp); end
      step();
    end
  endtask

`ifdef BIT_SERIALIZER_PARITY_EN
  // Hand-computed parity values: D0 has three ones, 03 has two.
  task automatic test_parity;
    logic [17:0] xs_exp, xs;
    logic [17:0] rdy_exp, rdy;
    xs_exp  = {8'hD0, 1'b1, 8'h03, 1'b0};
    rdy_exp = 18'b000000001_000000001;
    data_in = 8'hD0; data_valid = 1'b1;
    step();
    data_in = 8'h03;
    for (int i = 0; i < 18; i++) begin
      xs[17-i]  = x;
      rdy[17-i] = data_ready;
      checks++;
      if (x_valid !== 1'b1) begin errors++; $display("FAIL parity_valid[%0d] got %b want 1", i, x_valid); end
      if (i == 17) data_valid = 1'b0;
      step();
    end
    checks++;
    if (xs !== xs_exp) begin errors++; $display("FAIL parity_stream got %b want %b", xs, xs_exp); end
    checks++;
    if (rdy !== rdy_exp) begin errors++; $display("FAIL parity_ready got %b want %b", rdy, rdy_exp); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_reset_mid_word();
`ifdef BIT_SERIALIZER_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
